// File: rtl/mux4_scan_seq_if.sv
// Handshake/bus bundle between the mux scan sequencer and its neighbours.
// out_parity exists only when MUX4_SCAN_PARITY_EN is defined.
interface mux4_scan_seq_if;
  logic       start;
  logic       z;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
`ifdef MUX4_SCAN_PARITY_EN
  logic       out_parity;

  modport slave (
    input  start, z, out_ready,
    output s0, s1, busy, out_valid, out_data, out_parity
  );
  modport master (
    output start, z, out_ready,
    input  s0, s1, busy, out_valid, out_data, out_parity
  );
`else
  modport slave (
    input  start, z, out_ready,
    output s0, s1, busy, out_valid, out_data
  );
  modport master (
    output start, z, out_ready,
    input  s0, s1, busy, out_valid, out_data
  );
`endif
endinterface

// File: rtl/mux4_scan_seq.sv
// Steps a 4:1 mux through channels 0..3, samples z after SETTLE extra cycles
// per channel and hands the 4-bit word out on valid/ready. Optional: MUX4_SCAN_PARITY_EN.
module mux4_scan_seq #(
  parameter int unsigned SETTLE = 1
) (
  input logic            clk,
  input logic            rst_n,
  mux4_scan_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  logic [1:0] state;
  logic [1:0] k;
  logic [1:0] k_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] sample;
  logic       s0_q;
  logic       s1_q;
  logic       busy_q;
  logic       vld_q;
  logic [3:0] data_q;
`ifdef MUX4_SCAN_PARITY_EN
  logic       par_q;
  assign bus.out_parity = par_q;
`endif

  assign k_nxt         = k + 2'd1;
  assign bus.s0        = s0_q;
  assign bus.s1        = s1_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= 2'd0;
      wait_cnt <= 4'd0;
      sample   <= 4'd0;
      s0_q     <= 1'b1;
      s1_q     <= 1'b1;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= 4'd0;
`ifdef MUX4_SCAN_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SCAN;
            k        <= 2'd0;
            wait_cnt <= 4'd0;
            busy_q   <= 1'b1;
          end
        end
        SCAN: begin
          if (wait_cnt != SETTLE_W) begin
            wait_cnt <= wait_cnt + 4'd1;
          end else begin
            wait_cnt  <= 4'd0;
            sample[k] <= bus.z;
            if (k != 2'd3) begin
              // select moves on the same edge that samples the old channel
              k    <= k_nxt;
              s0_q <= ~k_nxt[1];
              s1_q <= ~k_nxt[0];
            end else begin
              data_q <= {bus.z, sample[2:0]};
`ifdef MUX4_SCAN_PARITY_EN
              par_q  <= ^{bus.z, sample[2:0]};
`endif
              vld_q  <= 1'b1;
              busy_q <= 1'b0;
              s0_q   <= 1'b1;
              s1_q   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            k     <= 2'd0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
